// File: rtl/sound_sched.sv
// sound_sched: queues one-cycle sound requests from the motion logic and plays them one at
// a time on the shared tone generator, each for DUR_FRAMES frames followed by GAP_FRAMES
// silent frames. A stop request preempts everything and flushes the queue.
//
// Ports:
//   clk_i          system clock
//   clr_ni         asynchronous active-low reset
//   frame_tick_i   one-cycle strobe per video frame
//   req_i[3:0]     request strobes: bit0 ping, bit1 pong, bit2 go, bit3 stop
//   mute_o         1 = buzzer silent
//   code_sound_o   sound being played: 00 ping, 01 pong, 10 go, 11 stop
//   busy_o         1 while playing, in the gap, or with sounds queued
//   overflow_o     sticky: a ping/pong/go request was dropped on a full queue
module sound_sched #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DUR_FRAMES = 6,
   parameter int unsigned GAP_FRAMES = 2
) (
   input  logic       clk_i,
   input  logic       clr_ni,
   input  logic       frame_tick_i,
   input  logic [3:0] req_i,
   output logic       mute_o,
   output logic [1:0] code_sound_o,
   output logic       busy_o,
   output logic       overflow_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FillW = PtrW + 1;
   localparam logic [FillW-1:0] FillFull = FillW'(DEPTH);
   localparam logic [7:0] DurLast = 8'(DUR_FRAMES);
   localparam logic [7:0] GapLast = 8'(GAP_FRAMES);

   typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

   state_e           state_q;
   logic [7:0]       frame_cnt_q;
   logic             mute_q;
   logic [1:0]       code_q;
   logic             busy_q;
   logic             ovf_q;

   logic [1:0]       mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FillW-1:0] fill_q, fill_d;

   logic             stop;
   logic             enq_req;
   logic [1:0]       enq_code;
   logic             full, empty;
   logic             push, pop;
   logic [1:0]       head;

   // Request selection: stop wins outright, otherwise go > pong > ping.
   always_comb begin
      stop     = req_i[3];
      enq_req  = ~req_i[3] & (|req_i[2:0]);
      enq_code = req_i[2] ? 2'b10 : (req_i[1] ? 2'b01 : 2'b00);
      full     = (fill_q == FillFull);
      empty    = (fill_q == '0);
      // Fullness is judged before any same-cycle pop.
      push     = enq_req & ~full;
      pop      = (state_q == StIdle) & ~empty & ~stop;
      head     = mem_q[rd_ptr_q];
      if (stop) begin
         fill_d = '0;
      end else begin
         fill_d = fill_q + FillW'(push) - FillW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         fill_q <= fill_d;
         if (stop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= enq_code;
   end

   always_ff @(posedge clk_i or negedge clr_ni) begin
      if (!clr_ni) begin
         state_q     <= StIdle;
         frame_cnt_q <= '0;
         mute_q      <= 1'b1;
         code_q      <= 2'b00;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         if (enq_req && full) ovf_q <= 1'b1;
         if (stop) begin
            state_q     <= StPlay;
            code_q      <= 2'b11;
            mute_q      <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (!empty) begin
                     state_q     <= StPlay;
                     code_q      <= head;
                     mute_q      <= 1'b0;
                     frame_cnt_q <= '0;
                     busy_q      <= 1'b1;
                  end else begin
                     mute_q <= 1'b1;
                     busy_q <= (fill_d != '0);
                  end
               end
               StPlay: begin
                  busy_q <= 1'b1;
                  if (frame_tick_i) begin
                     if (frame_cnt_q + 8'd1 == DurLast) begin
                        frame_cnt_q <= '0;
                        mute_q      <= 1'b1;
                        if (GAP_FRAMES == 0) begin
                           state_q <= StIdle;
                           busy_q  <= (fill_d != '0);
                        end else begin
                           state_q <= StGap;
                        end
                     end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                     end
                  end
               end
               StGap: begin
                  busy_q <= 1'b1;
                  if (frame_tick_i) begin
                     if (frame_cnt_q + 8'd1 == GapLast) begin
                        frame_cnt_q <= '0;
                        state_q     <= StIdle;
                        busy_q      <= (fill_d != '0);
                     end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign mute_o       = mute_q;
   assign code_sound_o = code_q;
   assign busy_o       = busy_q;
   assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_sound_sched.sv
// Bench for sound_sched: scoreboard of expected sound codes checked by a monitor whenever a
// new sound becomes audible, plus directed timing checks. A second instance covers zero gap.
module tb_sound_sched;

   localparam int Depth = 4;
   localparam int Dur = 3;
   localparam int Gap = 1;
   localparam int TickPeriod = 20;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] req = 4'd0;
   logic [3:0] req0 = 4'd0;
   logic       mute, busy, ovf;
   logic [1:0] code;
   logic       mute0, busy0, ovf0;
   logic [1:0] code0;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [1:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   logic [2:0] burst_q[$];

   sound_sched #(.DEPTH(Depth), .DUR_FRAMES(Dur), .GAP_FRAMES(Gap)) dut (
      .clk_i(clk), .clr_ni(clr_n), .frame_tick_i(tick), .req_i(req),
      .mute_o(mute), .code_sound_o(code), .busy_o(busy), .overflow_o(ovf)
   );

   sound_sched #(.DEPTH(Depth), .DUR_FRAMES(Dur), .GAP_FRAMES(0)) dut0 (
      .clk_i(clk), .clr_ni(clr_n), .frame_tick_i(tick), .req_i(req0),
      .mute_o(mute0), .code_sound_o(code0), .busy_o(busy0), .overflow_o(ovf0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      tick = ((cyc % TickPeriod) == 0);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] sel_code(input logic [2:0] v);
      if (v[2]) return 2'b10;
      if (v[1]) return 2'b01;
      return 2'b00;
   endfunction

   // Monitor: a sound starts when mute falls, or when the code changes while audible
   // (stop preemption). Counts ticks heard while audible and checks the length at the end.
   logic       mon_prev_mute = 1'b1;
   logic [1:0] mon_prev_code = 2'b00;
   bit         mon_active = 1'b0;
   int         mon_ticks = 0;

   always @(negedge clk) begin
      if (!clr_n) begin
         mon_active = 1'b0;
         mon_prev_mute = 1'b1;
      end else begin
         if (!mute && (mon_prev_mute || code != mon_prev_code)) begin
            if (exp_q.size() == 0) check("unexpected_sound", int'(code), -1);
            else check("sound_code", int'(code), int'(exp_q.pop_front()));
            mon_active = 1'b1;
            mon_ticks = 0;
         end
         if (!mon_prev_mute && mute && mon_active) begin
            check("sound_len_ticks", mon_ticks, Dur);
            mon_active = 1'b0;
         end
         if (!mute && tick) mon_ticks++;
         mon_prev_mute = mute;
         mon_prev_code = code;
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", int'(busy), 0);
   endtask

   task automatic wait_mute(input logic val, input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (mute !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (mute !== val) check(name, int'(mute), int'(val));
   endtask

   // Issue burst_q on consecutive cycles from idle. Reference: the first accepted request
   // at cycle a leaves the queue at cycle a+2; nothing else drains during a short burst.
   task automatic run_burst();
      int acc = 0;
      int first = -1;
      int occ;
      foreach (burst_q[j]) begin
         @(posedge clk);
         #1 req = {1'b0, burst_q[j]};
         if (burst_q[j] != 3'd0) begin
            occ = acc - ((first >= 0 && j >= first + 2) ? 1 : 0);
            if (occ >= Depth) begin
               exp_ovf = 1'b1;
            end else begin
               exp_q.push_back(sel_code(burst_q[j]));
               if (first < 0) first = j;
               acc++;
            end
         end
      end
      @(posedge clk);
      #1 req = 4'd0;
      wait_idle(3000);
      check("overflow_after_burst", int'(ovf), int'(exp_ovf));
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int len;

      repeat (3) @(posedge clk);
      #1;
      check("rst_mute", int'(mute), 1);
      check("rst_code", int'(code), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overflow", int'(ovf), 0);
      check("rst_mute_gap0", int'(mute0), 1);
      @(posedge clk);
      #3 clr_n = 1'b1;

      // Single ping: audible two edges after the request, one gap frame, then idle.
      @(posedge clk);
      #1 req = 4'b0001;
      exp_q.push_back(2'b00);
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      check("ping_mute_t1", int'(mute), 1);
      check("ping_busy_t1", int'(busy), 1);
      @(negedge clk);
      check("ping_mute_t2", int'(mute), 0);
      check("ping_code_t2", int'(code), 0);
      wait_mute(1'b1, 200, "ping_end_timeout");
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ping_gap_cycles", n, TickPeriod);
      check("ping_idle_mute", int'(mute), 1);
      check("ping_overflow", int'(ovf), 0);

      // Simultaneous ping+pong+go: only go.
      burst_q = {3'b111};
      run_burst();

      // Six consecutive pongs: one popped, four queued, the sixth dropped.
      burst_q = {3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
      run_burst();
      check("six_pong_overflow", int'(ovf), 1);

      // Random bursts against the reference model.
      for (int b = 0; b < 8; b++) begin
         burst_q = {};
         len = $urandom_range(1, 7);
         for (int k = 0; k < len; k++) burst_q.push_back(3'($urandom_range(0, 7)));
         run_burst();
      end

      // Stop preemption during the first of three queued sounds.
      @(posedge clk);
      #1 req = 4'b0001;
      exp_q.push_back(2'b00);
      @(posedge clk);
      #1 req = 4'b0010;
      @(posedge clk);
      #1 req = 4'b0100;
      @(posedge clk);
      #1 req = 4'b0000;
      wait_mute(1'b0, 50, "stop_first_sound_timeout");
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 req = 4'b1000;
      exp_q.push_back(2'b11);
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      check("stop_mute", int'(mute), 0);
      check("stop_code", int'(code), 3);
      wait_idle(3000);
      check("stop_queue_drained", exp_q.size(), 0);

      // Zero gap: two queued pings separated by exactly one idle cycle.
      @(posedge clk);
      #1 req0 = 4'b0001;
      @(posedge clk);
      #1 req0 = 4'b0001;
      @(posedge clk);
      #1 req0 = 4'b0000;
      n = 0;
      while (mute0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("gap0_first_mute", int'(mute0), 0);
      check("gap0_first_code", int'(code0), 0);
      n = 0;
      while (!mute0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (mute0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("gap0_idle_cycles", n, 1);
      check("gap0_second_code", int'(code0), 0);
      n = 0;
      while (busy0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("gap0_idle", int'(busy0), 0);

      // Reset mid-sound with another sound queued.
      @(posedge clk);
      #1 req = 4'b0001;
      exp_q.push_back(2'b00);
      @(posedge clk);
      #1 req = 4'b0010;
      @(posedge clk);
      #1 req = 4'b0000;
      wait_mute(1'b0, 50, "rst_sound_timeout");
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 clr_n = 1'b0;
      #1;
      check("async_rst_mute", int'(mute), 1);
      check("async_rst_overflow", int'(ovf), 0);
      check("async_rst_busy", int'(busy), 0);
      exp_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #3 clr_n = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (!mute) n++;
      end
      check("post_rst_silent_cycles", n, 0);
      check("post_rst_busy", int'(busy), 0);
      check("final_queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
